mem_data_access_ctrl: RTL and testbench
=======================================

Name: mem_data_access_ctrl

Overview:
- Sequences the MEM-stage data-memory access onto the SRAM-like data bus.
- Drives the data_stall bit of the pipeline stall vector, which freezes the EX/MEM register while an access is outstanding.
- Holds load data for an instruction that finishes its access while the pipeline is frozen for another reason.
- Discards in-flight responses that belong to instructions killed by an exception.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus data width

Ports:
clock_i  in  1  clock
reset_i  in  1  reset
req_read_i  in  1  MEM instruction is a load (EX/MEM mem_to_reg)
req_write_i  in  1  MEM instruction is a store (EX/MEM ram_write_enable)
req_addr_i  in  ADDR_W  EX/MEM ram address
req_wdata_i  in  DATA_W  EX/MEM ram write data
req_wstrb_i  in  4  byte enables from MEM-stage decode
req_size_i  in  2  0=byte, 1=half, 2=word
advance_i  in  1  EX/MEM register loads new contents this cycle (no exe/data stall)
exception_i  in  1  pipeline flush this cycle
data_req_o  out  1  bus request
data_wr_o  out  1  1=write
data_size_o  out  2  access size
data_addr_o  out  ADDR_W  address
data_wstrb_o  out  4  byte strobes
data_wdata_o  out  DATA_W  write data
data_addr_ok_i  in  1  address accepted
data_data_ok_i  in  1  response / write done
data_rdata_i  in  DATA_W  read data
data_stall_o  out  1  stall_i[3] of the stall vector
rdata_o  out  DATA_W  load result to the MEM stage
rdata_valid_o  out  1  rdata_o belongs to the current MEM instruction

Behaviour:
- Reset is asynchronous and active-high on reset_i; clock is clock_i, rising edge.
- Reset state: state=IDLE, rdata latch=0. Resulting outputs: data_req_o=0, data_stall_o=0, rdata_valid_o=0, rdata_o=0.
- has_req = (req_read_i | req_write_i) & ~exception_i.
- At most one access outstanding.
- Bus fields are combinational pass-through of the req_* inputs: data_wr_o=req_write_i, size, addr, wstrb, wdata.
- States:
  - IDLE: data_req_o=has_req. If has_req and addr_ok -> DATA; if has_req and no addr_ok -> ADDR.
  - ADDR: data_req_o=1 while ~exception_i.
    - addr_ok & ~exception_i -> DATA.
    - exception_i & addr_ok -> DRAIN.
    - exception_i & ~addr_ok -> IDLE (request withdrawn).
  - DATA: data_req_o=0.
    - data_ok & exception_i -> IDLE; data discarded.
    - data_ok & ~exception_i -> latch data_rdata_i (reads only). Next state IDLE if advance_i, else DONE.
    - ~data_ok & exception_i -> DRAIN.
  - DONE: data_req_o=0; rdata_o comes from the latch. advance_i or exception_i -> IDLE.
  - DRAIN: data_req_o=0. data_ok -> IDLE, response dropped; the latch is not updated.
- data_stall_o:
  - IDLE: has_req & ~addr_ok, or has_req & addr_ok (the response is still pending).
  - ADDR: 1.
  - DATA: ~data_ok_i.
  - DONE: 0.
  - DRAIN: has_req (a new instruction waits for the drain to finish).
  - Always forced to 0 while exception_i=1.
- Latency: the stall releases combinationally in the data_ok cycle, so the best-case load holds EX/MEM for 1 extra cycle when addr_ok and data_ok arrive in consecutive cycles.
- rdata_o:
  - data_rdata_i when state=DATA & data_ok & req_read_i.
  - Latch when state=DONE.
  - Otherwise the latch value.
- rdata_valid_o = (DATA & data_ok & req_read_i & ~exception_i) | (DONE & req_read_i).
- Boundaries:
  - A completed access is never reissued while state=DONE, even if advance_i stays 0 for many cycles.
  - addr_ok in IDLE without has_req is ignored.
  - data_ok in IDLE or ADDR is a protocol error; state is unchanged.
  - Reset mid-access returns to IDLE immediately; a bus response arriving after reset is ignored.

Decomposition:
- Shared package (defines.vh): state encodings IDLE/ADDR/DATA/DONE/DRAIN (3 bits) and size codes SIZE_B/SIZE_H/SIZE_W.
- Single module; no sub-module needed.

Test Plan:
- Load to 0x1000: addr_ok in cycle 0, data_ok=1 with rdata 0xDEADBEEF in cycle 1, advance_i=1 -> stall high only in cycle 0, rdata_o=0xDEADBEEF with valid in cycle 1, state IDLE in cycle 2.
- Store word 0x12345678 to 0x2004 with wstrb 0xF, addr_ok delayed 3 cycles -> data_req_o held 4 cycles with stable fields; stall drops on data_ok.
- Load completes while advance_i=0 for 5 cycles -> DONE, no second data_req_o, rdata_o stable, valid=1. Raising advance_i -> IDLE.
- exception_i in cycle after addr_ok (state DATA), data_ok 2 cycles later with 0xAAAA5555 -> DRAIN. A new load presented meanwhile sees stall=1 and no req until drain completes. The latch does not capture 0xAAAA5555.
- exception_i while in ADDR without addr_ok -> req drops the same cycle, state IDLE, stall 0.
- reset_i asserted mid-DATA -> outputs go to reset values asynchronously; a following stray data_ok is ignored.

Source files
------------

// File: rtl/mem_data_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-bus access controller: FSM state
// encodings and bus access size codes.
package mem_data_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_data_access_ctrl_if.sv
// SRAM-like data bus between the MEM-stage access controller (master) and
// the data memory (slave).
interface mem_data_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );

endinterface

// File: rtl/mem_data_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one bus access at a time,
// stalls EX/MEM while it is outstanding, and parks load data until MEM advances.
module mem_data_access_ctrl
    import mem_data_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  req_read_i,
    input  logic                  req_write_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [3:0]            req_wstrb_i,
    input  logic [1:0]            req_size_i,
    input  logic                  advance_i,
    input  logic                  exception_i,
    mem_data_access_ctrl_if.master bus,
    output logic                  data_stall_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rdata_valid_o
);

    state_e            state_r;
    logic [DATA_W-1:0] rdata_r;
    logic              has_req_s;
    logic              req_s;
    logic              stall_s;
    logic              resp_rd_s;

    // A killed instruction never counts as a live request.
    always_comb begin
        has_req_s = (req_read_i | req_write_i) & ~exception_i;
    end

    // Access sequencing FSM and load-data latch.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (has_req_s && bus.data_addr_ok) begin
                        state_r <= ST_DATA;
                    end else if (has_req_s) begin
                        state_r <= ST_ADDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (exception_i && bus.data_addr_ok) begin
                        state_r <= ST_DRAIN;
                    end else if (exception_i) begin
                        state_r <= ST_IDLE;
                    end else if (bus.data_addr_ok) begin
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (bus.data_data_ok && exception_i) begin
                        state_r <= ST_IDLE;
                    end else if (bus.data_data_ok) begin
                        if (req_read_i) begin
                            rdata_r <= bus.data_rdata;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r <= advance_i ? ST_IDLE : ST_DONE;
                    end else if (exception_i) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                // Completed access parks here so it is never reissued.
                ST_DONE: begin
                    if (advance_i || exception_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.data_data_ok) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-state bus request and raw stall before exception masking.
    always_comb begin
        req_s   = 1'b0;
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_s   = has_req_s;
                stall_s = has_req_s;
            end
            ST_ADDR: begin
                req_s   = ~exception_i;
                stall_s = 1'b1;
            end
            ST_DATA: begin
                req_s   = 1'b0;
                stall_s = ~bus.data_data_ok;
            end
            ST_DONE: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
            end
            ST_DRAIN: begin
                req_s   = 1'b0;
                stall_s = has_req_s;
            end
            default: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
            end
        endcase
    end

    // Bus fields pass straight through; the stall releases in the data_ok cycle.
    always_comb begin
        bus.data_req   = req_s;
        bus.data_wr    = req_write_i;
        bus.data_size  = req_size_i;
        bus.data_addr  = req_addr_i;
        bus.data_wstrb = req_wstrb_i;
        bus.data_wdata = req_wdata_i;
        data_stall_o   = stall_s & ~exception_i;
    end

    // Load result: live bus data in the response cycle, latch otherwise.
    always_comb begin
        resp_rd_s     = (state_r == ST_DATA) & bus.data_data_ok & req_read_i;
        rdata_o       = resp_rd_s ? bus.data_rdata : rdata_r;
        rdata_valid_o = (resp_rd_s & ~exception_i)
                      | ((state_r == ST_DONE) & req_read_i);
    end

endmodule

// File: tb/tb_mem_data_access_ctrl.sv
// Directed bench for mem_data_access_ctrl with hand-computed expectations.
module tb_mem_data_access_ctrl;
    import mem_data_access_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic              req_read_i;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic [3:0]        req_wstrb_i;
    logic [1:0]        req_size_i;
    logic              advance_i;
    logic              exception_i;
    logic              data_stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_data_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_data_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .req_read_i    (req_read_i),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_wstrb_i   (req_wstrb_i),
        .req_size_i    (req_size_i),
        .advance_i     (advance_i),
        .exception_i   (exception_i),
        .bus           (bus),
        .data_stall_o  (data_stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_i           = 1'b1;
        req_read_i        = 1'b0;
        req_write_i       = 1'b0;
        req_addr_i        = 32'h0;
        req_wdata_i       = 32'h0;
        req_wstrb_i       = 4'h0;
        req_size_i        = SIZE_W;
        advance_i         = 1'b0;
        exception_i       = 1'b0;
        bus.data_addr_ok  = 1'b0;
        bus.data_data_ok  = 1'b0;
        bus.data_rdata    = 32'h0;
        settle();
        chk("rst_req",   {31'd0, bus.data_req},  32'd0);
        chk("rst_stall", {31'd0, data_stall_o},  32'd0);
        chk("rst_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("rst_rdata", rdata_o,                32'h0);
        cyc();
        cyc();
        reset_i = 1'b0;

        // addr_ok without a request is ignored
        bus.data_addr_ok = 1'b1;
        settle();
        chk("idle_aok_req", {31'd0, bus.data_req}, 32'd0);
        cyc();
        bus.data_addr_ok = 1'b0;
        settle();
        chk("idle_aok_stall", {31'd0, data_stall_o}, 32'd0);

        // Test 1: best-case load
        req_read_i = 1'b1; req_addr_i = 32'h0000_1000; req_size_i = SIZE_W;
        bus.data_addr_ok = 1'b1;
        settle();
        chk("ld1_req",   {31'd0, bus.data_req}, 32'd1);
        chk("ld1_stall", {31'd0, data_stall_o}, 32'd1);
        chk("ld1_wr",    {31'd0, bus.data_wr},  32'd0);
        chk("ld1_addr",  bus.data_addr,         32'h0000_1000);
        cyc();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hDEAD_BEEF; advance_i = 1'b1;
        settle();
        chk("ld1_c1_stall", {31'd0, data_stall_o},  32'd0);
        chk("ld1_c1_rdata", rdata_o,                32'hDEAD_BEEF);
        chk("ld1_c1_valid", {31'd0, rdata_valid_o}, 32'd1);
        chk("ld1_c1_req",   {31'd0, bus.data_req},  32'd0);
        cyc();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; advance_i = 1'b0;
        settle();
        chk("ld1_c2_idle_req", {31'd0, bus.data_req}, 32'd1);
        req_read_i = 1'b0;
        settle();
        chk("ld1_c2_stall", {31'd0, data_stall_o},  32'd0);
        chk("ld1_c2_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("ld1_c2_latch", rdata_o,                32'hDEAD_BEEF);
        cyc();

        // Test 2: store with addr_ok delayed 3 cycles
        req_write_i = 1'b1; req_addr_i = 32'h0000_2004;
        req_wdata_i = 32'h1234_5678; req_wstrb_i = 4'hF; req_size_i = SIZE_W;
        for (int i = 0; i < 4; i++) begin
            bus.data_addr_ok = (i == 3) ? 1'b1 : 1'b0;
            settle();
            chk("st_req",   {31'd0, bus.data_req},  32'd1);
            chk("st_stall", {31'd0, data_stall_o},  32'd1);
            chk("st_wr",    {31'd0, bus.data_wr},   32'd1);
            chk("st_addr",  bus.data_addr,          32'h0000_2004);
            chk("st_wdata", bus.data_wdata,         32'h1234_5678);
            chk("st_wstrb", {28'd0, bus.data_wstrb}, 32'h0000_000F);
            chk("st_size",  {30'd0, bus.data_size}, 32'd2);
            cyc();
        end
        bus.data_addr_ok = 1'b0;
        settle();
        chk("st_wait_req",   {31'd0, bus.data_req}, 32'd0);
        chk("st_wait_stall", {31'd0, data_stall_o}, 32'd1);
        cyc();
        bus.data_data_ok = 1'b1; advance_i = 1'b1;
        settle();
        chk("st_ok_stall", {31'd0, data_stall_o},  32'd0);
        chk("st_ok_valid", {31'd0, rdata_valid_o}, 32'd0);
        cyc();
        bus.data_data_ok = 1'b0; advance_i = 1'b0; req_write_i = 1'b0;
        req_wstrb_i = 4'h0;
        settle();
        chk("st_end_req", {31'd0, bus.data_req}, 32'd0);
        cyc();

        // Test 3: load completes while pipeline frozen for 5 cycles
        req_read_i = 1'b1; req_addr_i = 32'h0000_3000; bus.data_addr_ok = 1'b1;
        settle();
        chk("ld3_req", {31'd0, bus.data_req}, 32'd1);
        cyc();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
        settle();
        chk("ld3_ok_stall", {31'd0, data_stall_o},  32'd0);
        chk("ld3_ok_rdata", rdata_o,                32'hCAFE_F00D);
        chk("ld3_ok_valid", {31'd0, rdata_valid_o}, 32'd1);
        cyc();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0BAD_BAD0; bus.data_addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("ld3_done_req",   {31'd0, bus.data_req},  32'd0);
            chk("ld3_done_stall", {31'd0, data_stall_o},  32'd0);
            chk("ld3_done_rdata", rdata_o,                32'hCAFE_F00D);
            chk("ld3_done_valid", {31'd0, rdata_valid_o}, 32'd1);
            cyc();
        end
        bus.data_addr_ok = 1'b0; advance_i = 1'b1;
        settle();
        chk("ld3_adv_valid", {31'd0, rdata_valid_o}, 32'd1);
        cyc();
        advance_i = 1'b0;
        settle();
        chk("ld3_idle_req", {31'd0, bus.data_req}, 32'd1);
        req_read_i = 1'b0;
        settle();
        chk("ld3_idle_rdata", rdata_o, 32'hCAFE_F00D);
        cyc();

        // Test 4: exception while in DATA, then drain
        req_read_i = 1'b1; req_addr_i = 32'h0000_4000; bus.data_addr_ok = 1'b1;
        settle();
        chk("ex4_req", {31'd0, bus.data_req}, 32'd1);
        cyc();
        bus.data_addr_ok = 1'b0; exception_i = 1'b1;
        settle();
        chk("ex4_exc_stall", {31'd0, data_stall_o},  32'd0);
        chk("ex4_exc_req",   {31'd0, bus.data_req},  32'd0);
        chk("ex4_exc_valid", {31'd0, rdata_valid_o}, 32'd0);
        cyc();
        exception_i = 1'b0; req_addr_i = 32'h0000_5000;
        settle();
        chk("ex4_drain_stall", {31'd0, data_stall_o}, 32'd1);
        chk("ex4_drain_req",   {31'd0, bus.data_req}, 32'd0);
        cyc();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hAAAA_5555;
        settle();
        chk("ex4_dok_stall", {31'd0, data_stall_o},  32'd1);
        chk("ex4_dok_req",   {31'd0, bus.data_req},  32'd0);
        chk("ex4_dok_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("ex4_dok_rdata", rdata_o,                32'hCAFE_F00D);
        cyc();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; bus.data_addr_ok = 1'b1;
        settle();
        chk("ex4_new_req",   {31'd0, bus.data_req}, 32'd1);
        chk("ex4_new_latch", rdata_o,               32'hCAFE_F00D);
        cyc();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h600D_600D; advance_i = 1'b1;
        settle();
        chk("ex4_new_valid", {31'd0, rdata_valid_o}, 32'd1);
        chk("ex4_new_rdata", rdata_o,                32'h600D_600D);
        cyc();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; advance_i = 1'b0;
        req_read_i = 1'b0;
        settle();
        chk("ex4_end_latch", rdata_o, 32'h600D_600D);
        cyc();

        // Test 5: exception in ADDR without addr_ok withdraws the request
        req_write_i = 1'b1; req_addr_i = 32'h0000_7001; req_size_i = SIZE_B;
        req_wstrb_i = 4'b0010; req_wdata_i = 32'h0000_AB00;
        settle();
        chk("ex5_size", {30'd0, bus.data_size}, 32'd0);
        cyc();
        settle();
        chk("ex5_addr_req",   {31'd0, bus.data_req}, 32'd1);
        chk("ex5_addr_stall", {31'd0, data_stall_o}, 32'd1);
        exception_i = 1'b1;
        settle();
        chk("ex5_exc_req",   {31'd0, bus.data_req}, 32'd0);
        chk("ex5_exc_stall", {31'd0, data_stall_o}, 32'd0);
        cyc();
        exception_i = 1'b0; req_write_i = 1'b0; req_size_i = SIZE_W; req_wstrb_i = 4'h0;
        settle();
        chk("ex5_idle_req",   {31'd0, bus.data_req}, 32'd0);
        chk("ex5_idle_stall", {31'd0, data_stall_o}, 32'd0);
        cyc();

        // Test 6: asynchronous reset mid-DATA, stray response afterwards
        req_read_i = 1'b1; req_addr_i = 32'h0000_8000; bus.data_addr_ok = 1'b1;
        settle();
        chk("rs6_req", {31'd0, bus.data_req}, 32'd1);
        cyc();
        bus.data_addr_ok = 1'b0;
        settle();
        chk("rs6_data_stall", {31'd0, data_stall_o}, 32'd1);
        chk("rs6_data_rdata", rdata_o,               32'h600D_600D);
        req_read_i = 1'b0; reset_i = 1'b1;
        settle();
        chk("rs6_rst_stall", {31'd0, data_stall_o},  32'd0);
        chk("rs6_rst_rdata", rdata_o,                32'h0);
        chk("rs6_rst_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("rs6_rst_req",   {31'd0, bus.data_req},  32'd0);
        cyc();
        reset_i = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5EED_BEEF;
        settle();
        chk("rs6_stray_stall", {31'd0, data_stall_o},  32'd0);
        chk("rs6_stray_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("rs6_stray_rdata", rdata_o,                32'h0);
        cyc();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; req_read_i = 1'b1;
        settle();
        chk("rs6_idle_req",   {31'd0, bus.data_req}, 32'd1);
        chk("rs6_idle_rdata", rdata_o,               32'h0);
        req_read_i = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
